// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU batch sequencer.
package alu_seq_pkg;

  localparam int ALU_ADDR_W  = 5;
  localparam int ALU_DATA_W  = 18;
  localparam int ALU_RES_W   = 8;
  localparam int ALU_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    EMIT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ALU_ADDR_W-1:0] addr;
    logic [ALU_RES_W-1:0]  re;
    logic [ALU_RES_W-1:0]  im;
  } result_t;

endpackage

// File: rtl/alu_batch_sequencer.sv
// Walks a batch of ROM addresses through one shared ROM + ALU lane and streams
// each complex result, tagged with its address, out over a valid/ready port.
module alu_batch_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W  = ALU_ADDR_W,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int RES_W   = ALU_RES_W,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] alu_data,
  output logic              alu_load,
  input  logic [RES_W-1:0]  alu_res_r,
  input  logic [RES_W-1:0]  alu_res_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [RES_W-1:0]  out_r,
  output logic [RES_W-1:0]  out_i,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] alu_data_q;
  logic              alu_load_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [RES_W-1:0]  out_r_q;
  logic [RES_W-1:0]  out_i_q;
  logic              busy_q;
  logic              done_q;

  // Batch FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= LEN_W'(0);
      idx_q       <= LEN_W'(0);
      cnt_q       <= CNT_W'(0);
      rom_addr_q  <= ADDR_W'(0);
      alu_data_q  <= DATA_W'(0);
      alu_load_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= ADDR_W'(0);
      out_r_q     <= RES_W'(0);
      out_i_q     <= RES_W'(0);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      alu_load_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != LEN_W'(0)) begin
              len_q      <= len;
              idx_q      <= LEN_W'(0);
              rom_addr_q <= base;
              state_q    <= FETCH;
            end else begin
              state_q <= FIN;
            end
          end
        end
        FETCH: state_q <= LOAD;
        // ROM word for rom_addr_q is valid here, one cycle after FETCH.
        LOAD: begin
          alu_data_q <= rom_data;
          alu_load_q <= 1'b1;
          cnt_q      <= CNT_W'(ALU_LAT - 1);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_W'(0)) begin
            out_r_q     <= alu_res_r;
            out_i_q     <= alu_res_i;
            out_addr_q  <= rom_addr_q;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == len_q - LEN_W'(1)) begin
              state_q <= FIN;
            end else begin
              idx_q      <= idx_q + LEN_W'(1);
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
              state_q    <= FETCH;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign alu_data  = alu_data_q;
  assign alu_load  = alu_load_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_batch_sequencer.sv
// Randomized bench for alu_batch_sequencer with ROM (mem[a]=a*3) and ALU
// (re=data[7:0], im=data[15:8]) models and a per-batch reference of results.
module tb_alu_batch_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  base;
  logic [5:0]  len;
  logic [4:0]  rom_addr;
  logic [17:0] rom_data;
  logic [17:0] alu_data;
  logic        alu_load;
  logic [7:0]  alu_res_r;
  logic [7:0]  alu_res_i;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [7:0]  out_r;
  logic [7:0]  out_i;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  int cur_base = 0;
  int cur_len = 0;
  int batch_acc0 = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  int first_acc_k = -1;
  int last_acc_k = -1;
  int done_k = -1;
  int ld0, dn0, bz0, st0;

  alu_batch_sequencer #(
    .ADDR_W(5), .DATA_W(18), .RES_W(8), .ALU_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .alu_data(alu_data),
    .alu_load(alu_load), .alu_res_r(alu_res_r), .alu_res_i(alu_res_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_r(out_r), .out_i(out_i), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= 18'(rom_addr) * 18'd3;

  always @(posedge clk) begin
    if (rst) begin
      alu_res_r <= 8'd0;
      alu_res_i <= 8'd0;
    end else if (alu_load) begin
      alu_res_r <= alu_data[7:0];
      alu_res_i <= alu_data[15:8];
    end
  end

  task automatic check_val(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Consumer: mode 0 always ready, mode 1 random, mode 2 stalls word 1 for 6 cycles.
  initial begin : ready_drv
    int held_cycles;
    held_cycles = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2 && out_valid && (acc_cnt - batch_acc0) == 1 && held_cycles < 6) begin
        out_ready = 1'b0;
        held_cycles++;
      end else out_ready = 1'b1;
      if (ready_mode != 2) held_cycles = 0;
    end
  end

  // Output monitor and scoreboard against the batch definition.
  initial begin : monitor
    logic    stall_prev;
    result_t held;
    result_t want;
    int      k;
    int      off;
    int      a;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rst) stall_prev = 1'b0;
      else begin
        k = cyc - start_cyc - 1;
        if (alu_load) load_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_k = k;
          check_val("busy_at_done", busy, 0);
        end
        if (out_valid) begin
          check_val("load_in_emit", alu_load, 0);
          if (stall_prev) begin
            check_val("hold_addr", out_addr, held.addr);
            check_val("hold_r", out_r, held.re);
            check_val("hold_i", out_i, held.im);
          end
          if (out_ready) begin
            off = acc_cnt - batch_acc0;
            check_val("acc_in_range", (off < cur_len) ? 1 : 0, 1);
            a = (cur_base + off) % 32;
            want.addr = 5'(a);
            want.re = 8'((a * 3) % 256);
            want.im = 8'((a * 3) / 256);
            check_val("out_addr", out_addr, want.addr);
            check_val("out_r", out_r, want.re);
            check_val("out_i", out_i, want.im);
            if (ready_mode == 0 && off > 0) check_val("spacing", k - last_acc_k, 5);
            if (off == 0) first_acc_k = k;
            last_acc_k = k;
            acc_cnt++;
            stall_prev = 1'b0;
          end else begin
            stall_cnt++;
            held.addr = out_addr;
            held.re = out_r;
            held.im = out_i;
            stall_prev = 1'b1;
          end
        end else stall_prev = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rom_addr"}, rom_addr, 0);
    check_val({tag, "_alu_data"}, alu_data, 0);
    check_val({tag, "_alu_load"}, alu_load, 0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_addr"}, out_addr, 0);
    check_val({tag, "_out_r"}, out_r, 0);
    check_val({tag, "_out_i"}, out_i, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  task automatic begin_batch(input int b, input int l, input int mode);
    @(posedge clk);
    #1;
    ready_mode = mode;
    cur_base = b;
    cur_len = l;
    batch_acc0 = acc_cnt;
    ld0 = load_cnt;
    dn0 = done_cnt;
    bz0 = busy_cnt;
    st0 = stall_cnt;
    start = 1'b1;
    base = 5'(b);
    len = 6'(l);
    start_cyc = cyc;
  endtask

  task automatic finish_batch(input bit junk);
    bit got;
    got = 1'b0;
    for (int k = 1; k <= 40 * 33 + 60; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt != dn0) begin
        start = 1'b0;
        got = 1'b1;
        break;
      end
      if (junk && k <= 5 * cur_len + 1) begin
        start = 1'($urandom_range(0, 1));
        base = 5'($urandom);
        len = 6'($urandom);
      end else start = 1'b0;
    end
    check_val("done_seen", got, 1);
    repeat (2) @(posedge clk);
    #1;
    check_val("n_done", done_cnt - dn0, 1);
    check_val("n_loads", load_cnt - ld0, cur_len);
    check_val("n_accepts", acc_cnt - batch_acc0, cur_len);
    check_val("busy_cycles", busy_cnt - bz0, done_k - 1);
    if (cur_len == 0) check_val("done_lat_len0", done_k, 2);
    else if (ready_mode == 1) check_val("done_after_acc", done_k, last_acc_k + 2);
    else begin
      check_val("first_valid", first_acc_k, 5);
      check_val("done_lat", done_k, 5 * cur_len + 2 + ((ready_mode == 2) ? 6 : 0));
      check_val("stall_cycles", stall_cnt - st0, (ready_mode == 2) ? 6 : 0);
    end
  endtask

  task automatic run_batch(input int b, input int l, input int mode, input bit junk);
    begin_batch(b, l, mode);
    finish_batch(junk);
  endtask

  initial begin : main
    bit got;
    int d0;
    int l;
    rst = 1'b1;
    start = 1'b0;
    base = 5'd0;
    len = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_batch(0, 4, 0, 1'b0);
    run_batch(int'($urandom_range(0, 31)), 0, 0, 1'b0);
    run_batch(30, 4, 0, 1'b0);
    run_batch(int'($urandom_range(0, 31)), 4, 2, 1'b0);

    // Abort in the first WAIT cycle of word 2.
    begin_batch(10, 4, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (alu_load && (acc_cnt - batch_acc0) == 2) begin
        got = 1'b1;
        break;
      end
    end
    check_val("t5_reached_wait", got, 1);
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    check_reset_outputs("t5");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("t5_no_done", done_cnt - d0, 0);
    run_batch(5, 1, 0, 1'b0);

    run_batch(int'($urandom_range(0, 31)), 3, 0, 1'b1);
    run_batch(int'($urandom_range(0, 31)), 32, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      l = (n == 3) ? 32 : int'($urandom_range(0, 32));
      run_batch(int'($urandom_range(0, 31)), l, int'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
